// File: rtl/pc_sequencer_pkg.sv
// Shared types and constants for the PC sequencer.
// Holds the run-state encoding and the drain-slot instruction value.
package pc_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } pc_state_e;

    // Instruction memory holds this (a nop) at END_PC.
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    function automatic logic misaligned(input logic [31:0] a);
        return a[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Link between the sequencer and the core's fetch/hazard logic.
// master: drives PC, takes PC_Write and Next_Addr; slave is the core side.
interface pc_seq_if;
    logic        PC_Write;
    logic [31:0] Next_Addr;
    logic [31:0] PC;

    modport master (
        output PC,
        input  PC_Write,
        input  Next_Addr
    );

    modport slave (
        input  PC,
        output PC_Write,
        output Next_Addr
    );
endinterface

// File: rtl/pc_sequencer_sat_counter.sv
// Saturating up-counter: clears on rst or clr, sticks at all-ones.
// Ports: clk, rst, clr, inc in; q out (W bits).
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            q <= '0;
        end else if (inc && (q != '1)) begin
            q <= q + 1'b1;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// PC sequencer: IDLE/RUN/DRAIN/DONE run bracket plus perf counters.
// Ports: clk, rst, start in; bus (PC out, PC_Write/Next_Addr in);
// running, done, err, cycle_cnt, fetch_cnt, stall_cnt out.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter logic [31:0] END_PC       = 32'h0000_0100,
    parameter int          DRAIN_CYCLES = 4,
    parameter int          CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    pc_seq_if.master         bus,
    output logic             running,
    output logic             done,
    output logic             err,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] fetch_cnt,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int DW =
        (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DW-1:0] DLOAD = DW'(DRAIN_CYCLES - 1);

    pc_state_e     state;
    logic [DW-1:0] dcnt;

    logic go;
    logic in_run;
    logic adv;

    // Start is only honoured from IDLE or DONE.
    assign go     = start && ((state == IDLE) || (state == DONE));
    assign in_run = (state == RUN);
    assign adv    = in_run && bus.PC_Write && !misaligned(bus.Next_Addr);

    sat_counter #(.W(CNT_W)) u_cycle (
        .clk (clk),
        .rst (rst),
        .clr (go),
        .inc ((state == RUN) || (state == DRAIN)),
        .q   (cycle_cnt)
    );

    sat_counter #(.W(CNT_W)) u_fetch (
        .clk (clk),
        .rst (rst),
        .clr (go),
        .inc (adv),
        .q   (fetch_cnt)
    );

    sat_counter #(.W(CNT_W)) u_stall (
        .clk (clk),
        .rst (rst),
        .clr (go),
        .inc (in_run && !bus.PC_Write),
        .q   (stall_cnt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            bus.PC  <= RESET_PC;
            running <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
            dcnt    <= '0;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    if (state == IDLE) begin
                        bus.PC <= RESET_PC;
                    end
                    if (start) begin
                        bus.PC  <= RESET_PC;
                        err     <= 1'b0;
                        done    <= 1'b0;
                        running <= 1'b1;
                        // Empty program goes straight to the drain.
                        if (RESET_PC == END_PC) begin
                            state <= DRAIN;
                            dcnt  <= DLOAD;
                        end else begin
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (bus.PC_Write) begin
                        // Misalignment wins over the END_PC compare.
                        if (misaligned(bus.Next_Addr)) begin
                            err     <= 1'b1;
                            state   <= DONE;
                            running <= 1'b0;
                            done    <= 1'b1;
                        end else begin
                            bus.PC <= bus.Next_Addr;
                            if (bus.Next_Addr == END_PC) begin
                                state <= DRAIN;
                                dcnt  <= DLOAD;
                            end
                        end
                    end
                end
                DRAIN: begin
                    if (dcnt == '0) begin
                        state   <= DONE;
                        running <= 1'b0;
                        done    <= 1'b1;
                    end else begin
                        dcnt <= dcnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: stimulus queues expectations,
// monitors compare PC per running cycle, final counters and snapshots.
module tb_pc_sequencer;

    typedef struct {
        logic [31:0] pc;
        logic        run;
        logic        dn;
        logic        er;
        logic [31:0] c;
        logic [31:0] f;
        logic [31:0] s;
    } snap_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        pw;
    logic        bad_en;
    logic [31:0] bad_addr;
    logic        running, done, err;
    logic [31:0] cycle_cnt, fetch_cnt, stall_cnt;

    logic        sc_clr, sc_inc;
    logic [1:0]  sc_q;

    int n_chk  = 0;
    int n_fail = 0;

    logic [31:0] pc_q[$];
    snap_t       fin_q[$];
    snap_t       snap_q[$];
    event        snap_ev;
    logic        done_d = 1'b0;

    pc_seq_if cif();

    assign cif.PC_Write  = pw;
    assign cif.Next_Addr = bad_en ? bad_addr : cif.PC + 32'd4;

    always #5 clk = ~clk;

    pc_sequencer #(
        .RESET_PC     (32'h0),
        .END_PC       (32'h10),
        .DRAIN_CYCLES (4),
        .CNT_W        (32)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .bus       (cif),
        .running   (running),
        .done      (done),
        .err       (err),
        .cycle_cnt (cycle_cnt),
        .fetch_cnt (fetch_cnt),
        .stall_cnt (stall_cnt)
    );

    sat_counter #(.W(2)) u_sc (
        .clk (clk),
        .rst (rst),
        .clr (sc_clr),
        .inc (sc_inc),
        .q   (sc_q)
    );

    function automatic void chk(string nm, logic [31:0] act,
                                logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endfunction

    function automatic void cmp_snap(string tag, snap_t e);
        chk({tag, ".pc"},      cif.PC,    e.pc);
        chk({tag, ".running"}, 32'(running), 32'(e.run));
        chk({tag, ".done"},    32'(done),    32'(e.dn));
        chk({tag, ".err"},     32'(err),     32'(e.er));
        chk({tag, ".cycle"},   cycle_cnt, e.c);
        chk({tag, ".fetch"},   fetch_cnt, e.f);
        chk({tag, ".stall"},   stall_cnt, e.s);
    endfunction

    // Per-cycle PC and end-of-run monitor.
    always @(negedge clk) begin
        if (running) begin
            if (pc_q.size() == 0) begin
                chk("pc_q_empty", cif.PC, 32'hxxxx_xxxx);
            end else begin
                chk("pc_seq", cif.PC, pc_q.pop_front());
            end
        end
        if (done && !done_d) begin
            if (fin_q.size() == 0) begin
                chk("fin_q_empty", 32'd1, 32'd0);
            end else begin
                cmp_snap("final", fin_q.pop_front());
            end
        end
        done_d = done;
    end

    // On-demand snapshot monitor.
    always @(snap_ev) begin
        if (snap_q.size() != 0) begin
            cmp_snap("snap", snap_q.pop_front());
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic snap(snap_t e);
        snap_q.push_back(e);
        -> snap_ev;
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done();
        int k = 0;
        while (!done && k < 100) begin
            tick();
            k++;
        end
        n_chk++;
        if (!done) begin
            n_fail++;
            $display("FAIL wait_done: got done=%b expected 1", done);
        end
        tick();
    endtask

    task automatic push_pcs(logic [31:0] a[]);
        foreach (a[i]) pc_q.push_back(a[i]);
    endtask

    snap_t s_idle  = '{32'h0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0};
    snap_t s_go    = '{32'h0, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0};
    snap_t f_line  = '{32'h10, 1'b0, 1'b1, 1'b0, 32'd8, 32'd4, 32'd0};
    snap_t f_stall = '{32'h10, 1'b0, 1'b1, 1'b0, 32'd10, 32'd4, 32'd2};
    snap_t f_bad   = '{32'h4, 1'b0, 1'b1, 1'b1, 32'd2, 32'd1, 32'd0};

    logic [31:0] seq_line[]  = '{32'h0, 32'h4, 32'h8, 32'hC,
                                 32'h10, 32'h10, 32'h10, 32'h10};
    logic [31:0] seq_stall[] = '{32'h0, 32'h4, 32'h4, 32'h4, 32'h8,
                                 32'hC, 32'h10, 32'h10, 32'h10,
                                 32'h10};
    logic [31:0] seq_bad[]   = '{32'h0, 32'h4};
    logic [31:0] seq_rst[]   = '{32'h0, 32'h4, 32'h8};

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        pw       = 1'b1;
        bad_en   = 1'b0;
        bad_addr = 32'h0;
        sc_clr   = 1'b0;
        sc_inc   = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        repeat (10) tick();
        snap(s_idle);

        // Straight-line run.
        push_pcs(seq_line);
        fin_q.push_back(f_line);
        pulse_start();
        snap(s_go);
        wait_done();

        // Restart from DONE reproduces the same run.
        push_pcs(seq_line);
        fin_q.push_back(f_line);
        pulse_start();
        snap(s_go);
        wait_done();

        // Stalls on RUN cycles 2 and 3.
        push_pcs(seq_stall);
        fin_q.push_back(f_stall);
        pulse_start();
        pw = 1'b1;
        tick();
        pw = 1'b0;
        tick();
        tick();
        pw = 1'b1;
        wait_done();

        // Misaligned Next_Addr while at PC=4.
        push_pcs(seq_bad);
        fin_q.push_back(f_bad);
        pulse_start();
        tick();
        bad_en   = 1'b1;
        bad_addr = 32'h6;
        tick();
        bad_en = 1'b0;
        snap(f_bad);
        tick();

        // Restart clears err.
        push_pcs(seq_line);
        fin_q.push_back(f_line);
        pulse_start();
        snap(s_go);
        wait_done();

        // Reset together with start in the 3rd RUN cycle.
        push_pcs(seq_rst);
        pulse_start();
        tick();
        tick();
        rst   = 1'b1;
        start = 1'b1;
        tick();
        rst   = 1'b0;
        start = 1'b0;
        snap(s_idle);
        tick();

        // Saturation of a narrow counter.
        sc_inc = 1'b1;
        repeat (5) tick();
        sc_inc = 1'b0;
        chk("sat_hold", 32'(sc_q), 32'd3);
        sc_clr = 1'b1;
        tick();
        sc_clr = 1'b0;
        chk("sat_clr", 32'(sc_q), 32'd0);

        tick();
        tick();
        chk("pc_q_left", pc_q.size(), 32'd0);
        chk("fin_q_left", fin_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Program-counter sequencer sitting directly upstream of the pipelined CPU core. Holds the PC that drives the core's instruction address input. Advances it with the core's PC+4 result whenever the core's hazard unit permits. Brackets a program run with a start/drain/done FSM and keeps cycle, fetch and stall counters for the test harness.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000: address of first instruction fetched after start
- END_PC, 32'h0000_0100: first address past the program; reaching it ends fetch
- DRAIN_CYCLES, 4: cycles held after END_PC so the last instruction reaches write-back
- CNT_W, 32: width of each performance counter

Ports:
- clk  in  1  core clock; all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; begins a run from RESET_PC
- PC_Write  in  1  from core hazard detection; 1 = PC may advance, 0 = load-use stall
- Next_Addr  in  32  core's PC+4 (its Output_Addr)
- PC  out  32  current fetch address, wired to core Input_Addr
- running  out  1  1 in RUN or DRAIN
- done  out  1  1 in DONE
- err  out  1  sticky misalignment flag
- cycle_cnt  out  CNT_W  cycles spent in RUN+DRAIN
- fetch_cnt  out  CNT_W  PC advances in RUN
- stall_cnt  out  CNT_W  RUN cycles with PC_Write=0

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- Reset values:
  - state IDLE, PC=RESET_PC
  - running=0, done=0, err=0
  - all counters 0
- IDLE:
  - PC held at RESET_PC.
  - On start: clear counters and err.
  - If RESET_PC==END_PC, go to DRAIN; else go to RUN.
- RUN, every cycle:
  - cycle_cnt+1.
  - If PC_Write=1: PC<=Next_Addr, fetch_cnt+1.
  - If PC_Write=0: PC held, stall_cnt+1.
- RUN exits:
  - PC_Write=1 and Next_Addr==END_PC: move to DRAIN; PC becomes END_PC.
  - PC_Write=1 and Next_Addr[1:0]!=0: err<=1, move to DONE, PC held. This check takes priority over the END_PC compare.
- DRAIN:
  - PC held at END_PC; PC_Write ignored. Instruction memory holds zero (nop) at END_PC.
  - Down-counter loaded with DRAIN_CYCLES-1 on entry; cycle_cnt+1 each cycle.
  - Go to DONE when the down-counter is 0, i.e. after exactly DRAIN_CYCLES cycles.
- DONE:
  - done=1; counters and PC frozen.
  - start re-enters the IDLE start action: clear counters and err, PC<=RESET_PC, go to RUN.
- Counters saturate at all-ones; they never wrap.
- start in RUN or DRAIN is ignored.
- rst overrides start and every other event in the same cycle. rst mid-run returns to reset values next edge.

## Timing
- Registered outputs only; no combinational path from inputs to PC, running or done.
- start sampled at edge N → running=1 after edge N. The core fetches RESET_PC during cycle N+1.
- PC_Write sampled at edge → PC updates on that same edge. One-cycle stall leaves PC unchanged for exactly one extra cycle.
- done rises on the edge following the last DRAIN cycle.
- Counters are valid and stable once done=1.

## Structure
- Shared package pc_seq_pkg holds:
  - state enum, 2-bit encoding: IDLE=0, RUN=1, DRAIN=2, DONE=3
  - NOP_INSTR constant 32'h0000_0000
- One sub-module, sat_counter (parameter W; inputs clr, inc; output q, saturating). Instantiated three times for the cycle, fetch and stall counters.
- Drain down-counter stays inline in the FSM.

## Test plan
- Reset then idle: rst high 2 cycles, no start → PC=0, running=0, done=0, all counters 0 after 10 cycles.
- Straight-line run, END_PC=0x10, PC_Write tied 1, Next_Addr=PC+4:
  - PC sequence 0,4,8,C,10
  - DRAIN 4 cycles, then done=1
  - fetch_cnt=4, stall_cnt=0, cycle_cnt=8
- Stalls: same run with PC_Write=0 on the 2nd and 3rd RUN cycles → PC holds 4 for 3 cycles; fetch_cnt=4, stall_cnt=2, cycle_cnt=10.
- Misalignment: Next_Addr=0x6 with PC_Write=1 → err=1, done=1 next edge, PC frozen at previous value, no DRAIN.
- Reset mid-run: rst asserted in the 3rd RUN cycle together with start → next edge state IDLE, PC=RESET_PC, counters 0, running=0.
- Restart from DONE: start pulse after completion → counters cleared, PC=RESET_PC, running=1; second run reproduces identical counter values.
